// File: rtl/mac_pipe_pkg.sv
// rtl/mac_pipe_pkg.sv - shared mode type, default sizes and saturating add for mac_pipe
package mac_pipe_pkg;

    typedef enum logic {
        MODE_MADD = 1'b0,
        MODE_ACC  = 1'b1
    } mode_e;

    localparam int MAC_WIDTH   = 8;
    localparam int MAC_ACC_LEN = 16;

    typedef struct packed {
        logic [63:0] sum;
        logic        sat;
    } sat_res_t;

    // Operands arrive pre-extended to 64 bits; the result is clamped to a w-bit range.
    function automatic sat_res_t sat_add(input logic [63:0] x, input logic [63:0] y,
                                         input int unsigned w, input logic sgn);
        sat_res_t r;
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = $signed({sgn & x[63], x}) + $signed({sgn & y[63], y});
        hi = sgn ? (65'sd1 <<< (w - 1)) - 65'sd1 : (65'sd1 <<< w) - 65'sd1;
        lo = sgn ? -(65'sd1 <<< (w - 1)) : 65'sd0;
        r.sat = 1'b1;
        if (s > hi) begin
            r.sum = hi[63:0];
        end else if (s < lo) begin
            r.sum = lo[63:0];
        end else begin
            r.sum = s[63:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_pipe_mul_stage.sv
// rtl/mac_pipe_mul_stage.sv - stage 1 of mac_pipe: product, bias capture and extension
module mac_mul_stage
    import mac_pipe_pkg::*;
#(
    parameter int WIDTH     = MAC_WIDTH,
    parameter int ACC_WIDTH = 2*WIDTH+4,
    parameter int SIGNED    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    input  logic                 mode,
    output logic                 v1,
    output mode_e                mode1,
    output logic [ACC_WIDTH-1:0] p1,
    output logic [ACC_WIDTH-1:0] c1
);

    localparam logic SX = (SIGNED != 0);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] p1_q;
    logic [WIDTH-1:0]   c_q;
    logic               take;

    // Low 2*WIDTH bits of the extended product are exact for either signedness.
    assign a_ext = {{WIDTH{SX & a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{SX & b[WIDTH-1]}}, b};
    assign prod  = a_ext * b_ext;
    assign take  = in_valid & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            mode1 <= MODE_MADD;
            p1_q  <= '0;
            c_q   <= '0;
        end else begin
            v1 <= take;
            if (take) begin
                p1_q  <= prod;
                c_q   <= c;
                mode1 <= mode_e'(mode);
            end
        end
    end

    assign p1 = {{(ACC_WIDTH-2*WIDTH){SX & p1_q[2*WIDTH-1]}}, p1_q};
    assign c1 = {{(ACC_WIDTH-WIDTH){SX & c_q[WIDTH-1]}}, c_q};

endmodule

// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - two-stage multiply-add / multiply-accumulate unit; MAC_SAT_EN selects saturating sums
module mac_pipe
    import mac_pipe_pkg::*;
#(
    parameter int WIDTH     = MAC_WIDTH,
    parameter int ACC_WIDTH = 2*WIDTH+4,
    parameter int SIGNED    = 1,
    parameter int ACC_LEN   = MAC_ACC_LEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [WIDTH-1:0]           c,
    input  logic                       mode,
    input  logic                       clr,
    output logic                       out_valid,
    output logic [ACC_WIDTH-1:0]       data_out,
    output logic [$clog2(ACC_LEN)-1:0] acc_cnt,
    output logic                       ovf
);

    localparam int CW = $clog2(ACC_LEN);

    logic                 v1;
    mode_e                mode1;
    logic [ACC_WIDTH-1:0] p1;
    logic [ACC_WIDTH-1:0] c1;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] base;
    logic [ACC_WIDTH-1:0] madd_sum;
    logic [ACC_WIDTH-1:0] acc_sum;

    mac_mul_stage #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SIGNED    (SIGNED)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .c        (c),
        .mode     (mode),
        .v1       (v1),
        .mode1    (mode1),
        .p1       (p1),
        .c1       (c1)
    );

    // The first product of a burst is seeded with the bias instead of the stale sum.
    assign base = (acc_cnt == '0) ? c1 : acc;

`ifdef MAC_SAT_EN
    localparam logic SX = (SIGNED != 0);

    function automatic logic [63:0] to64(input logic [ACC_WIDTH-1:0] v);
        return {{(64-ACC_WIDTH){SX & v[ACC_WIDTH-1]}}, v};
    endfunction

    sat_res_t r_madd;
    sat_res_t r_acc;

    assign r_madd   = sat_add(to64(p1), to64(c1), ACC_WIDTH, SX);
    assign r_acc    = sat_add(to64(base), to64(p1), ACC_WIDTH, SX);
    assign madd_sum = r_madd.sum[ACC_WIDTH-1:0];
    assign acc_sum  = r_acc.sum[ACC_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (v1 && ((mode1 == MODE_MADD) ? r_madd.sat : r_acc.sat)) begin
            ovf <= 1'b1;
        end
    end
`else
    assign madd_sum = p1 + c1;
    assign acc_sum  = base + p1;
    assign ovf      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            acc       <= '0;
            acc_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                acc     <= '0;
                acc_cnt <= '0;
            end else if (v1) begin
                if (mode1 == MODE_MADD) begin
                    data_out  <= madd_sum;
                    out_valid <= 1'b1;
                    acc_cnt   <= '0;
                end else begin
                    acc <= acc_sum;
                    if (acc_cnt == CW'(ACC_LEN-1)) begin
                        data_out  <= acc_sum;
                        out_valid <= 1'b1;
                        acc_cnt   <= '0;
                    end else begin
                        acc_cnt <= acc_cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule
